// File: rtl/collisions_pkg.sv
// Shared constants, state encoding and payload types for the collision-buffer controller.
package collisions_pkg;

  localparam int unsigned COLL_ADDR_W     = 10;
  localparam int unsigned COLL_DATA_W     = 64;
  localparam int unsigned COLL_WORD_W     = 16;
  localparam int unsigned COLL_LANES      = COLL_DATA_W / COLL_WORD_W;
  localparam int unsigned COLL_LANE_W     = $clog2(COLL_LANES);
  localparam int unsigned COLL_CPU_ADDR_W = COLL_ADDR_W + COLL_LANE_W;
  localparam int unsigned COLL_DEPTH      = 1 << COLL_ADDR_W;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } coll_state_t;

  typedef struct packed {
    logic [COLL_ADDR_W-1:0] addr;
    logic [COLL_DATA_W-1:0] mask;
  } gpu_req_t;

  // Extract one CPU word lane from a buffer row.
  function automatic logic [COLL_WORD_W-1:0] lane_word(input logic [COLL_DATA_W-1:0] row,
                                                       input logic [COLL_LANE_W-1:0] lane);
    return row[32'(lane)*COLL_WORD_W +: COLL_WORD_W];
  endfunction

endpackage

// File: rtl/collisions_if.sv
// Request/response and BRAM port bundle between GPU/CPU, the controller and the collision BRAM.
interface collisions_if;
  import collisions_pkg::*;

  logic                       frame_start;
  logic                       clear_busy;
  logic                       gpu_req_valid;
  logic                       gpu_req_ready;
  logic [COLL_ADDR_W-1:0]     gpu_req_addr;
  logic [COLL_DATA_W-1:0]     gpu_req_mask;
  logic                       cpu_rd_valid;
  logic                       cpu_rd_ready;
  logic [COLL_CPU_ADDR_W-1:0] cpu_rd_addr;
  logic [COLL_WORD_W-1:0]     cpu_rd_data;
  logic                       cpu_rd_data_valid;
  logic                       bram_cea;
  logic [COLL_ADDR_W-1:0]     bram_ada;
  logic [COLL_DATA_W-1:0]     bram_din;
  logic                       bram_ceb;
  logic [COLL_ADDR_W-1:0]     bram_adb;
  logic                       bram_oce;
  logic [COLL_DATA_W-1:0]     bram_dout;

  modport slave (
    input  frame_start, gpu_req_valid, gpu_req_addr, gpu_req_mask,
           cpu_rd_valid, cpu_rd_addr, bram_dout,
    output clear_busy, gpu_req_ready, cpu_rd_ready, cpu_rd_data, cpu_rd_data_valid,
           bram_cea, bram_ada, bram_din, bram_ceb, bram_adb, bram_oce
  );

  modport master (
    output frame_start, gpu_req_valid, gpu_req_addr, gpu_req_mask,
           cpu_rd_valid, cpu_rd_addr, bram_dout,
    input  clear_busy, gpu_req_ready, cpu_rd_ready, cpu_rd_data, cpu_rd_data_valid,
           bram_cea, bram_ada, bram_din, bram_ceb, bram_adb, bram_oce
  );

endinterface

// File: rtl/collisions_rr_arb.sv
// Two-requester round-robin arbiter for BRAM port B; the CPU wins the first contested cycle.
module collisions_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic gpu_valid,
  input  logic cpu_valid,
  output logic gpu_grant,
  output logic cpu_grant
);

  logic last_cpu_q, last_cpu_d;

  // Priority only rotates on contested cycles; a lone requester always wins.
  always_comb begin
    gpu_grant  = 1'b0;
    cpu_grant  = 1'b0;
    last_cpu_d = last_cpu_q;
    if (en) begin
      if (gpu_valid && cpu_valid) begin
        cpu_grant  = ~last_cpu_q;
        gpu_grant  = last_cpu_q;
        last_cpu_d = ~last_cpu_q;
      end else begin
        cpu_grant = cpu_valid;
        gpu_grant = gpu_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_cpu_q <= 1'b0;
    else       last_cpu_q <= last_cpu_d;
  end

endmodule

// File: rtl/collisions_ctrl.sv
// Collision-buffer sequencer: clears the BRAM per frame, runs GPU mark read-modify-write
// at one per cycle with write forwarding, and serves CPU word reads over port B.
module collisions_ctrl
  import collisions_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  collisions_if.slave bus
);

  coll_state_t                state_q, state_d;
  logic [COLL_ADDR_W-1:0]     clear_cnt_q, clear_cnt_d;
  logic                       s1_valid_q, s1_valid_d;
  gpu_req_t                   s1_q, s1_d;
  logic                       fwd_valid_q, fwd_valid_d;
  logic [COLL_ADDR_W-1:0]     fwd_addr_q, fwd_addr_d;
  logic [COLL_DATA_W-1:0]     fwd_data_q, fwd_data_d;
  logic                       rd_pend_q, rd_pend_d;
  logic [COLL_LANE_W-1:0]     lane_q, lane_d;
  logic [COLL_WORD_W-1:0]     rd_data_q, rd_data_d;
  logic                       rd_data_valid_q, rd_data_valid_d;

  logic                       arb_en_c;
  logic                       gpu_grant, cpu_grant;
  logic [COLL_DATA_W-1:0]     base, wr_data;

  assign arb_en_c = ~reset & (state_q == IDLE) & ~bus.frame_start;

  collisions_rr_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (arb_en_c),
    .gpu_valid (bus.gpu_req_valid),
    .cpu_valid (bus.cpu_rd_valid),
    .gpu_grant (gpu_grant),
    .cpu_grant (cpu_grant)
  );

  // Row read last cycle may be stale if stage 1 wrote that same row last cycle.
  always_comb begin
    base    = (fwd_valid_q && (fwd_addr_q == s1_q.addr)) ? fwd_data_q : bus.bram_dout;
    wr_data = base | s1_q.mask;
  end

  // Port drive: stage-1 write owns port A, otherwise the clear sweep; held idle in reset.
  always_comb begin
    bus.gpu_req_ready     = gpu_grant;
    bus.cpu_rd_ready      = cpu_grant;
    bus.clear_busy        = (state_q != IDLE);
    bus.cpu_rd_data       = rd_data_q;
    bus.cpu_rd_data_valid = rd_data_valid_q;
    bus.bram_oce          = 1'b1;
    bus.bram_ceb          = gpu_grant | cpu_grant;
    bus.bram_adb          = '0;
    bus.bram_cea          = 1'b0;
    bus.bram_ada          = '0;
    bus.bram_din          = '0;
    if (gpu_grant) begin
      bus.bram_adb = bus.gpu_req_addr;
    end else if (cpu_grant) begin
      bus.bram_adb = bus.cpu_rd_addr[COLL_CPU_ADDR_W-1:COLL_LANE_W];
    end
    if (!reset) begin
      if (s1_valid_q) begin
        bus.bram_cea = 1'b1;
        bus.bram_ada = s1_q.addr;
        bus.bram_din = wr_data;
      end else if (state_q == CLEAR) begin
        bus.bram_cea = 1'b1;
        bus.bram_ada = clear_cnt_q;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    clear_cnt_d     = clear_cnt_q;
    s1_valid_d      = gpu_grant;
    s1_d            = s1_q;
    fwd_valid_d     = s1_valid_q;
    fwd_addr_d      = fwd_addr_q;
    fwd_data_d      = fwd_data_q;
    rd_pend_d       = cpu_grant;
    lane_d          = lane_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = rd_pend_q;

    unique case (state_q)
      CLEAR: begin
        if (bus.frame_start) begin
          clear_cnt_d = '0;
        end else if (clear_cnt_q == COLL_ADDR_W'(COLL_DEPTH - 1)) begin
          clear_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          clear_cnt_d = clear_cnt_q + COLL_ADDR_W'(1);
        end
      end
      IDLE: begin
        if (bus.frame_start) state_d = DRAIN;
      end
      DRAIN: begin
        clear_cnt_d = '0;
        state_d     = CLEAR;
      end
      default: state_d = CLEAR;
    endcase

    if (gpu_grant) begin
      s1_d.addr = bus.gpu_req_addr;
      s1_d.mask = bus.gpu_req_mask;
    end
    if (s1_valid_q) begin
      fwd_addr_d = s1_q.addr;
      fwd_data_d = wr_data;
    end
    if (cpu_grant) lane_d = bus.cpu_rd_addr[COLL_LANE_W-1:0];
    if (rd_pend_q) rd_data_d = lane_word(bus.bram_dout, lane_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= CLEAR;
      clear_cnt_q     <= '0;
      s1_valid_q      <= 1'b0;
      s1_q            <= '0;
      fwd_valid_q     <= 1'b0;
      fwd_addr_q      <= '0;
      fwd_data_q      <= '0;
      rd_pend_q       <= 1'b0;
      lane_q          <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      clear_cnt_q     <= clear_cnt_d;
      s1_valid_q      <= s1_valid_d;
      s1_q            <= s1_d;
      fwd_valid_q     <= fwd_valid_d;
      fwd_addr_q      <= fwd_addr_d;
      fwd_data_q      <= fwd_data_d;
      rd_pend_q       <= rd_pend_d;
      lane_q          <= lane_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
    end
  end

endmodule

// File: tb/tb_collisions_ctrl.sv
// Bench for collisions_ctrl: BRAM model, vector table, randomized traffic vs. a row-level model,
// and hand sequences for frame clears and asynchronous reset.
module tb_collisions_ctrl;
  import collisions_pkg::*;

  localparam int unsigned AW    = COLL_ADDR_W;
  localparam int unsigned CAW   = COLL_CPU_ADDR_W;
  localparam int unsigned DW    = COLL_DATA_W;
  localparam int unsigned DEPTH = COLL_DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  collisions_if bus();

  collisions_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Read-first simple-dual-port BRAM model
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.bram_ceb) bus.bram_dout <= mem[bus.bram_adb];
    if (bus.bram_cea) mem[bus.bram_ada] <= bus.bram_din;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit gv, input logic [AW-1:0] ga, input logic [DW-1:0] gm,
                       input bit cv, input logic [CAW-1:0] ca, input bit fs);
    bus.gpu_req_valid = gv;
    bus.gpu_req_addr  = ga;
    bus.gpu_req_mask  = gm;
    bus.cpu_rd_valid  = cv;
    bus.cpu_rd_addr   = ca;
    bus.frame_start   = fs;
  endtask

  // Runs n clear cycles from the current one, expecting rows 0..n-1 zeroed with ports blocked.
  task automatic run_clear(input int n, input string name);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.clear_busy !== 1'b1 || bus.bram_cea !== 1'b1 || bus.bram_ada !== AW'(i) ||
          bus.bram_din !== '0 || bus.gpu_req_ready !== 1'b0 || bus.cpu_rd_ready !== 1'b0) begin
        if (bad == 0)
          $display("FAIL %s row %0d: busy=%b cea=%b ada=%0d din=%h rdy=%b%b", name, i,
                   bus.clear_busy, bus.bram_cea, bus.bram_ada, bus.bram_din,
                   bus.gpu_req_ready, bus.cpu_rd_ready);
        bad++;
      end
      @(posedge clk); #1;
    end
    chk({name, "_bad_cycles"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    bit              gv;
    logic [AW-1:0]   ga;
    logic [DW-1:0]   gm;
    bit              cv;
    logic [CAW-1:0]  ca;
    bit              egr, ecr, ecea;
    logic [AW-1:0]   eada;
    logic [DW-1:0]   edin;
    bit              erdv;
    logic [15:0]     erd;
  } vec_t;

  function automatic vec_t mk(bit gv, int ga, logic [DW-1:0] gm, bit cv, int ca,
                              bit egr, bit ecr, bit ecea, int eada, logic [DW-1:0] edin,
                              bit erdv, logic [15:0] erd);
    vec_t v;
    v.gv = gv; v.ga = AW'(ga); v.gm = gm; v.cv = cv; v.ca = CAW'(ca);
    v.egr = egr; v.ecr = ecr; v.ecea = ecea; v.eada = AW'(eada); v.edin = edin;
    v.erdv = erdv; v.erd = erd;
    return v;
  endfunction

  // Row-level reference: rows 0..15, marks become visible to reads two cycles after acceptance.
  logic [DW-1:0] ref_mem [16];
  bit            cpu_turn = 1'b1;
  bit            pend_v = 1'b0;
  logic [3:0]    pend_a;
  logic [DW-1:0] pend_m;
  bit            q1v = 1'b0, q2v = 1'b0;
  logic [15:0]   q1d, q2d;

  task automatic rand_cycle(input bit gv, input logic [3:0] ga, input logic [DW-1:0] gm,
                            input bit cv, input logic [5:0] ca);
    bit eg, ec;
    logic [DW-1:0] rv;
    logic [15:0] rd_new = '0;
    drive(gv, AW'(ga), gm, cv, CAW'(ca), 1'b0);
    @(negedge clk);
    if (gv && cv) begin
      ec = cpu_turn; eg = !cpu_turn; cpu_turn = !cpu_turn;
    end else begin
      eg = gv; ec = cv;
    end
    chk("rnd_gpu_ready", 64'(bus.gpu_req_ready), 64'(eg));
    chk("rnd_cpu_ready", 64'(bus.cpu_rd_ready), 64'(ec));
    chk("rnd_rd_valid", 64'(bus.cpu_rd_data_valid), 64'(q2v));
    if (q2v) chk("rnd_rd_data", 64'(bus.cpu_rd_data), 64'(q2d));
    if (ec) begin
      rv = ref_mem[ca[5:2]];
      rd_new = rv[32'(ca[1:0])*16 +: 16];
    end
    if (pend_v) ref_mem[pend_a] = ref_mem[pend_a] | pend_m;
    chk("rnd_cea", 64'(bus.bram_cea), 64'(pend_v));
    if (pend_v) begin
      chk("rnd_ada", 64'(bus.bram_ada), 64'(pend_a));
      chk("rnd_din", bus.bram_din, ref_mem[pend_a]);
    end
    pend_v = eg; pend_a = ga; pend_m = gm;
    q2v = q1v; q2d = q1d;
    q1v = ec;  q1d = rd_new;
    @(posedge clk); #1;
  endtask

  vec_t vt[18];

  initial begin
    logic [DW-1:0] m;
    logic [DW-1:0] row7;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = {$urandom, $urandom};
    drive(1'b1, AW'(1), '1, 1'b1, CAW'(2), 1'b0);
    repeat (2) @(posedge clk);

    // Reset values while reset is held
    @(negedge clk);
    chk("rst_clear_busy", 64'(bus.clear_busy), 64'd1);
    chk("rst_cea", 64'(bus.bram_cea), 64'd0);
    chk("rst_ceb", 64'(bus.bram_ceb), 64'd0);
    chk("rst_gpu_ready", 64'(bus.gpu_req_ready), 64'd0);
    chk("rst_cpu_ready", 64'(bus.cpu_rd_ready), 64'd0);
    chk("rst_rd_valid", 64'(bus.cpu_rd_data_valid), 64'd0);
    chk("rst_rd_data", 64'(bus.cpu_rd_data), 64'd0);
    chk("rst_ada", 64'(bus.bram_ada), 64'd0);
    chk("rst_adb", 64'(bus.bram_adb), 64'd0);
    chk("rst_din", bus.bram_din, 64'd0);
    chk("oce", 64'(bus.bram_oce), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Initial clear with both requesters pushing
    run_clear(int'(DEPTH), "init_clear");

    vt[0]  = mk(1, 5, 64'h1, 0, 0,                    1, 0, 0, 0, '0, 0, 16'h0);
    vt[1]  = mk(1, 5, 64'h8000_0000_0000_0000, 0, 0,  1, 0, 1, 5, 64'h1, 0, 16'h0);
    vt[2]  = mk(0, 0, '0, 0, 0,                       0, 0, 1, 5, 64'h8000_0000_0000_0001, 0, 16'h0);
    vt[3]  = mk(0, 0, '0, 1, 20,                      0, 1, 0, 0, '0, 0, 16'h0);
    vt[4]  = mk(0, 0, '0, 1, 23,                      0, 1, 0, 0, '0, 0, 16'h0);
    vt[5]  = mk(0, 0, '0, 0, 0,                       0, 0, 0, 0, '0, 1, 16'h0001);
    vt[6]  = mk(0, 0, '0, 0, 0,                       0, 0, 0, 0, '0, 1, 16'h8000);
    vt[7]  = mk(0, 0, '0, 0, 0,                       0, 0, 0, 0, '0, 0, 16'h0);
    vt[8]  = mk(1, 9, 64'h0100, 1, 36,                0, 1, 0, 0, '0, 0, 16'h0);
    vt[9]  = mk(1, 9, 64'h0200, 1, 36,                1, 0, 0, 0, '0, 0, 16'h0);
    vt[10] = mk(1, 9, 64'h0400, 1, 36,                0, 1, 1, 9, 64'h0200, 1, 16'h0000);
    vt[11] = mk(1, 9, 64'h0800, 1, 36,                1, 0, 0, 0, '0, 0, 16'h0);
    vt[12] = mk(1, 9, 64'h1000, 1, 36,                0, 1, 1, 9, 64'h0A00, 1, 16'h0000);
    vt[13] = mk(1, 9, 64'h2000, 1, 36,                1, 0, 0, 0, '0, 0, 16'h0);
    vt[14] = mk(1, 9, 64'h4000, 1, 36,                0, 1, 1, 9, 64'h2A00, 1, 16'h0200);
    vt[15] = mk(1, 9, 64'h8000, 1, 36,                1, 0, 0, 0, '0, 0, 16'h0);
    vt[16] = mk(0, 0, '0, 0, 0,                       0, 0, 1, 9, 64'hAA00, 1, 16'h0A00);
    vt[17] = mk(0, 0, '0, 0, 0,                       0, 0, 0, 0, '0, 0, 16'h0);

    foreach (vt[i]) begin
      drive(vt[i].gv, vt[i].ga, vt[i].gm, vt[i].cv, vt[i].ca, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), 64'(bus.clear_busy), 64'd0);
      chk($sformatf("vec%0d_gpu_ready", i), 64'(bus.gpu_req_ready), 64'(vt[i].egr));
      chk($sformatf("vec%0d_cpu_ready", i), 64'(bus.cpu_rd_ready), 64'(vt[i].ecr));
      chk($sformatf("vec%0d_cea", i), 64'(bus.bram_cea), 64'(vt[i].ecea));
      if (vt[i].ecea) begin
        chk($sformatf("vec%0d_ada", i), 64'(bus.bram_ada), 64'(vt[i].eada));
        chk($sformatf("vec%0d_din", i), bus.bram_din, vt[i].edin);
      end
      chk($sformatf("vec%0d_rd_valid", i), 64'(bus.cpu_rd_data_valid), 64'(vt[i].erdv));
      if (vt[i].erdv) chk($sformatf("vec%0d_rd_data", i), 64'(bus.cpu_rd_data), 64'(vt[i].erd));
      @(posedge clk); #1;
    end

    // Randomized traffic on rows 0..15
    foreach (ref_mem[r]) ref_mem[r] = '0;
    ref_mem[5] = 64'h8000_0000_0000_0001;
    ref_mem[9] = 64'h0000_0000_0000_AA00;
    for (int n = 0; n < 400; n++) begin
      m = ($urandom % 4 == 0) ? {$urandom, $urandom} : (64'h1 << $urandom_range(0, 63));
      rand_cycle(($urandom % 4) != 0, 4'($urandom_range(0, 15)), m,
                 ($urandom % 3) != 0, 6'($urandom_range(0, 63)));
    end
    repeat (3) rand_cycle(1'b0, 4'd0, '0, 1'b0, 6'd0);
    for (int r = 0; r < 16; r++) chk($sformatf("rnd_row%0d", r), mem[r], ref_mem[r]);

    // Frame start right after a GPU accept on row 7
    row7 = ref_mem[7] | 64'h00F0;
    drive(1'b1, AW'(7), 64'h00F0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("fs_gpu_accept", 64'(bus.gpu_req_ready), 64'd1);
    @(posedge clk); #1;
    drive(1'b1, AW'(8), 64'hFFFF, 1'b1, CAW'(4), 1'b1);
    @(negedge clk);
    chk("fs_gpu_ready", 64'(bus.gpu_req_ready), 64'd0);
    chk("fs_cpu_ready", 64'(bus.cpu_rd_ready), 64'd0);
    chk("fs_cea", 64'(bus.bram_cea), 64'd1);
    chk("fs_ada", 64'(bus.bram_ada), 64'd7);
    chk("fs_din", bus.bram_din, row7);
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    @(negedge clk);
    chk("drain_busy", 64'(bus.clear_busy), 64'd1);
    chk("drain_gpu_ready", 64'(bus.gpu_req_ready), 64'd0);
    chk("drain_cpu_ready", 64'(bus.cpu_rd_ready), 64'd0);
    @(posedge clk); #1;
    run_clear(int'(DEPTH), "frame_clear");
    drive(1'b0, '0, '0, 1'b1, CAW'(28), 1'b0);
    @(negedge clk);
    chk("post_clear_busy", 64'(bus.clear_busy), 64'd0);
    chk("post_clear_cpu_ready", 64'(bus.cpu_rd_ready), 64'd1);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("word28_valid", 64'(bus.cpu_rd_data_valid), 64'd1);
    chk("word28_data", 64'(bus.cpu_rd_data), 64'd0);
    @(posedge clk); #1;

    // Frame start in the middle of a clear restarts the sweep
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    @(posedge clk); #1;
    run_clear(600, "clear_to_600");
    bus.frame_start = 1'b1;
    @(negedge clk);
    chk("restart_at_600_ada", 64'(bus.bram_ada), 64'd600);
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    run_clear(int'(DEPTH), "restart_clear");
    @(negedge clk);
    chk("restart_done_busy", 64'(bus.clear_busy), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset with a stage-1 write pending
    drive(1'b1, AW'(3), 64'h1, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("ar_accept", 64'(bus.gpu_req_ready), 64'd1);
    @(posedge clk); #1;
    bus.gpu_req_addr = AW'(4);
    @(negedge clk);
    chk("ar_pending_cea", 64'(bus.bram_cea), 64'd1);
    chk("ar_pending_ada", 64'(bus.bram_ada), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("ar_cea", 64'(bus.bram_cea), 64'd0);
    chk("ar_ceb", 64'(bus.bram_ceb), 64'd0);
    chk("ar_busy", 64'(bus.clear_busy), 64'd1);
    chk("ar_gpu_ready", 64'(bus.gpu_req_ready), 64'd0);
    chk("ar_rd_valid", 64'(bus.cpu_rd_data_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.gpu_req_valid = 1'b0;
    run_clear(4, "ar_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
